core_sequencer: RTL
===================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameters: none; all widths fixed as listed below.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 run  in  1  level; 1 = start or continue executing instructions.
REQ-005 imem_addr  out  8  instruction memory word address; combinational = pc[7:0].
REQ-006 imem_data  in  32  instruction memory read data; synchronous memory, valid one cycle after imem_addr.
REQ-007 ins  out  32  latched instruction, driven to the execute stage.
REQ-008 pc  out  32  current instruction word address, driven to the execute stage.
REQ-009 rs_addr  out  5  register-file read address 1; combinational = ins[25:21].
REQ-010 rt_addr  out  5  register-file read address 2; combinational = ins[20:16].
REQ-011 rf_rdata1, rf_rdata2  in  32 each  combinational register-file read data.
REQ-012 reg1, reg2  out  32 each  latched operands, driven to the execute stage.
REQ-013 wra  in  5  destination register from the execute stage.
REQ-014 result  in  32  write-back value from the execute stage.
REQ-015 nextpc  in  32  next PC from the execute stage.
REQ-016 rf_we  out  1  register-file write strobe.
REQ-017 rf_waddr  out  5  register-file write address.
REQ-018 rf_wdata  out  32  register-file write data.
REQ-019 halted  out  1  1 while in the HALT state.
REQ-020 busy  out  1  1 in every state except IDLE and HALT.
REQ-021 instr_count  out  32  count of retired instructions.

Function
REQ-022 States: IDLE, FETCH, DECODE, READ, EXEC, WB, HALT; held in a single registered state variable.
REQ-023 IDLE: if run=1, go to FETCH next cycle; otherwise remain in IDLE.
REQ-024 FETCH: imem_addr presents pc[7:0]; always go to DECODE.
REQ-025 DECODE: if imem_data[31:26]=6'h3f, go to HALT and leave ins unchanged; otherwise latch ins<=imem_data and go to READ.
REQ-026 READ: latch reg1<=rf_rdata1 and reg2<=rf_rdata2; go to EXEC.
REQ-027 EXEC: hold ins, pc, reg1 and reg2 stable; this one cycle lets the execute stage's synchronous data memory return load data; go to WB.
REQ-028 WB, same edge: pc<=nextpc; instr_count<=instr_count+1; then go to FETCH if run=1, else to IDLE.
REQ-029 rf_we=1 only in WB and only when wra!=0; rf_we=0 in all other states.
REQ-030 rf_waddr=wra and rf_wdata=result combinationally, at all times.
REQ-031 Latency: exactly 5 cycles per non-halt instruction (FETCH through WB); back-to-back instructions have no idle cycle when run stays 1.
REQ-032 ins, pc, reg1 and reg2 change only on the edges named above; between those edges they are stable.
REQ-033 run=0 while busy does not abort: the current instruction completes through WB, then the block enters IDLE.
REQ-034 HALT is left only by reset; run is ignored in HALT; in HALT rf_we=0 and pc is frozen.
REQ-035 pc is 32 bits and updates without truncation; imem_addr wraps modulo 256 through pc[7:0].
REQ-036 instr_count wraps from 32'hffffffff to 0.
REQ-037 A halt instruction is not counted and produces no write.

Reset
REQ-038 On a clk edge with rst_n=0, from any state: state<=IDLE; pc, ins, reg1, reg2 and instr_count <= 0.
REQ-039 rst_n=0 in WB suppresses that cycle's rf_we and pc update; reset has priority over all transitions.
REQ-040 After reset, outputs are: rf_we=0, halted=0, busy=0, imem_addr=0.

Verification
REQ-041 Reset then run=1, imem[0] = ADDI r1,r0,5 (32'h04010005), result=5 -> rf_we high for exactly 1 cycle at cycle 5 after leaving IDLE, with rf_waddr=1 and rf_wdata=5; pc=1; instr_count=1.
REQ-042 imem[0..2] = three ALU instructions, run held at 1 -> WB pulses 5 cycles apart; instr_count=3 after 15 cycles.
REQ-043 imem[1]=32'hfc000000 -> halted=1 after DECODE of word 1; pc stays 1; instr_count=1; run toggling has no effect until rst_n=0.
REQ-044 Drop run to 0 during READ -> instruction completes through WB, then the block enters IDLE with busy=0; raising run again resumes from the new pc.
REQ-045 Execute model drives wra=0 -> rf_we stays 0 in WB while pc still advances to nextpc.
REQ-046 Assert rst_n=0 during WB with nextpc=32'h40 -> no rf_we pulse; pc=0; state=IDLE. Separately, preload pc=32'hff with nextpc=32'h100 -> imem_addr=8'h00 after WB.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetches, decodes and reads operands, then waits
// one execute cycle and writes back. A 6'h3f opcode parks the block in HALT until reset.
module core_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ins,
  output logic [31:0] pc,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic [31:0] reg1,
  output logic [31:0] reg2,
  input  logic [4:0]  wra,
  input  logic [31:0] result,
  input  logic [31:0] nextpc,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        halted,
  output logic        busy,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_ins;
  logic [31:0] r_reg1;
  logic [31:0] r_reg2;
  logic [31:0] r_instr_count;
  logic        w_is_halt;

  assign w_is_halt = (imem_data[31:26] == 6'h3f);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   w_state_next = run ? S_FETCH : S_IDLE;
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: w_state_next = w_is_halt ? S_HALT : S_READ;
      S_READ:   w_state_next = S_EXEC;
      S_EXEC:   w_state_next = S_WB;
      S_WB:     w_state_next = run ? S_FETCH : S_IDLE;
      S_HALT:   w_state_next = S_HALT;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Each datapath register has exactly one state in which it may load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= 32'd0;
      r_ins         <= 32'd0;
      r_reg1        <= 32'd0;
      r_reg2        <= 32'd0;
      r_instr_count <= 32'd0;
    end else begin
      case (r_state)
        S_DECODE: begin
          if (!w_is_halt) begin
            r_ins <= imem_data;
          end
        end
        S_READ: begin
          r_reg1 <= rf_rdata1;
          r_reg2 <= rf_rdata2;
        end
        S_WB: begin
          r_pc          <= nextpc;
          r_instr_count <= r_instr_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr   = r_pc[7:0];
  assign ins         = r_ins;
  assign pc          = r_pc;
  assign rs_addr     = r_ins[25:21];
  assign rt_addr     = r_ins[20:16];
  assign reg1        = r_reg1;
  assign reg2        = r_reg2;
  assign instr_count = r_instr_count;

  // Gated by rst_n so a reset landing in WB never produces a write.
  assign rf_we    = (r_state == S_WB) && (wra != 5'd0) && rst_n;
  assign rf_waddr = wra;
  assign rf_wdata = result;
  assign halted   = (r_state == S_HALT);
  assign busy     = (r_state != S_IDLE) && (r_state != S_HALT);

endmodule
